// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store sequencer: FSM encoding,
// RV32I load/store funct3 values, access size codes and response error codes.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_FAULT    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: decodes funct3 and byte offset into byte enables,
// legality/alignment flags, lane-shifted store data and extended load data.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  byte_en,
  output logic        misaligned,
  output logic        illegal,
  output logic [31:0] wdata_sh,
  output logic [31:0] rdata_ext
);

  logic [1:0]  size;
  logic        sext;
  logic [31:0] lane_mask;
  logic [31:0] rd_sh;

  always_comb begin
    size       = funct3[1:0];
    sext       = ~funct3[2];
    // Unsigned forms exist only for loads, and only for byte/half.
    illegal    = (size == 2'b11) | (funct3[2] & (we | funct3[1]));
    misaligned = 1'b0;
    byte_en    = 4'b0000;
    case (size)
      SZ_B: byte_en = 4'b0001 << off;
      SZ_H: begin
        misaligned = (off == 2'd3);
        byte_en    = 4'b0011 << off;
      end
      SZ_W: begin
        misaligned = (off != 2'd0);
        byte_en    = 4'b1111;
      end
      default: byte_en = 4'b0000;
    endcase
    if (illegal || misaligned) byte_en = 4'b0000;

    lane_mask = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
    wdata_sh  = (wdata << {off, 3'b000}) & lane_mask;

    rd_sh = rdata_raw >> {off, 3'b000};
    case (size)
      SZ_B:    rdata_ext = {{24{sext & rd_sh[7]}}, rd_sh[7:0]};
      SZ_H:    rdata_ext = {{16{sext & rd_sh[15]}}, rd_sh[15:0]};
      default: rdata_ext = rd_sh;
    endcase
  end

endmodule

// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer: accepts one core access, runs a single req/ack memory
// transaction with timeout, and returns a one-cycle response with error code.
module lsu_mem_sequencer
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_byte_en,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic [1:0]  dbg_state
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  off_q, off_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [3:0]  mem_byte_en_q, mem_byte_en_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]  rsp_err_q, rsp_err_d;

  logic        a_we;
  logic [2:0]  a_funct3;
  logic [1:0]  a_off;
  logic [3:0]  a_byte_en;
  logic        a_misaligned, a_illegal;
  logic [31:0] a_wdata_sh, a_rdata_ext;

  // In IDLE the lane logic decodes the incoming request; afterwards it works on the held one.
  assign a_we     = (state_q == ST_IDLE) ? req_we         : we_q;
  assign a_funct3 = (state_q == ST_IDLE) ? req_funct3     : funct3_q;
  assign a_off    = (state_q == ST_IDLE) ? req_addr[1:0]  : off_q;

  lsu_lane_align u_align (
    .we         (a_we),
    .funct3     (a_funct3),
    .off        (a_off),
    .wdata      (req_wdata),
    .rdata_raw  (mem_rdata),
    .byte_en    (a_byte_en),
    .misaligned (a_misaligned),
    .illegal    (a_illegal),
    .wdata_sh   (a_wdata_sh),
    .rdata_ext  (a_rdata_ext)
  );

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high exactly while in IDLE, so at most one access is outstanding.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    funct3_d      = funct3_q;
    off_d         = off_q;
    cnt_d         = cnt_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_byte_en_d = mem_byte_en_q;
    mem_wdata_d   = mem_wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          off_d    = req_addr[1:0];
          if (a_illegal || a_misaligned) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = 32'h0;
            rsp_err_d   = a_illegal ? ERR_FAULT : ERR_MISALIGN;
          end else begin
            state_d       = ST_REQ;
            cnt_d         = 16'h0;
            mem_req_d     = 1'b1;
            mem_we_d      = req_we;
            mem_addr_d    = {req_addr[31:2], 2'b00};
            mem_byte_en_d = a_byte_en;
            mem_wdata_d   = a_wdata_sh;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = mem_err ? ERR_FAULT : ERR_NONE;
          rsp_rdata_d = (mem_err || we_q) ? 32'h0 : a_rdata_ext;
        end else if (cnt_q == TO_LAST) begin
          state_d     = ST_RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_TIMEOUT;
          rsp_rdata_d = 32'h0;
        end else begin
          cnt_d = cnt_q + 16'h1;
        end
      end
      ST_RESP: begin
        state_d     = ST_IDLE;
        rsp_rdata_d = 32'h0;
        rsp_err_d   = ERR_NONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      we_q          <= 1'b0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      cnt_q         <= 16'h0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'h0;
      mem_byte_en_q <= 4'h0;
      mem_wdata_q   <= 32'h0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      funct3_q      <= funct3_d;
      off_q         <= off_d;
      cnt_q         <= cnt_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_byte_en_q <= mem_byte_en_d;
      mem_wdata_q   <= mem_wdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_byte_en = mem_byte_en_q;
  assign mem_wdata   = mem_wdata_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Directed bench for lsu_mem_sequencer: hand-computed vectors for loads, stores,
// decode/alignment errors, bus fault, timeout and reset in the middle of an access.
module tb_lsu_mem_sequencer;
  import lsu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  logic [33:0] exp_q[$];

  lsu_mem_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_funct3  (req_funct3),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_byte_en (mem_byte_en),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .mem_err     (mem_err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: every response pulse is matched against the next expected {err, rdata}
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", {rsp_err, rsp_rdata}, 34'h3_FFFF_FFFF);
      end else begin
        check("rsp", {rsp_err, rsp_rdata}, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
    @(posedge clk);
    #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    check("req_ready_idle", 34'(req_ready), 34'(1));
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic ack_now(input logic [31:0] rdata, input logic err);
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    mem_err   = err;
    @(posedge clk);
    #1;
    mem_ack   = 1'b0;
    mem_err   = 1'b0;
    mem_rdata = 32'h0;
  endtask

  initial begin
    int req_cycles;
    int rsp_cyc;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'h0;
    mem_err    = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", 34'(rsp_valid), 34'(0));
    check("rst_rsp_rdata", 34'(rsp_rdata), 34'(0));
    check("rst_rsp_err", 34'(rsp_err), 34'(0));
    check("rst_mem_req", 34'(mem_req), 34'(0));
    check("rst_mem_we", 34'(mem_we), 34'(0));
    check("rst_mem_addr", 34'(mem_addr), 34'(0));
    check("rst_byte_en", 34'(mem_byte_en), 34'(0));
    check("rst_mem_wdata", 34'(mem_wdata), 34'(0));
    check("rst_req_ready", 34'(req_ready), 34'(1));
    check("rst_state", 34'(dbg_state), 34'(ST_IDLE));
    rst_n = 1'b1;

    // mem_ack while IDLE must be ignored
    @(posedge clk);
    #1;
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    check("idle_ack_state", 34'(dbg_state), 34'(ST_IDLE));
    check("idle_ack_rsp", 34'(rsp_valid), 34'(0));

    // LB 0x103: lane 3, 0x80 sign-extends
    exp_q.push_back({ERR_NONE, 32'hFFFF_FF80});
    issue(1'b0, F3_B, 32'h0000_0103, 32'h0);
    @(negedge clk);
    check("lb_mem_req", 34'(mem_req), 34'(1));
    check("lb_addr", 34'(mem_addr), 34'h100);
    check("lb_byte_en", 34'(mem_byte_en), 34'b1000);
    check("lb_mem_we", 34'(mem_we), 34'(0));
    check("lb_req_ready", 34'(req_ready), 34'(0));
    #4;
    ack_now(32'h80AA_BBCC, 1'b0);
    @(negedge clk);
    check("lb_rsp_t2", 34'(rsp_valid), 34'(1));
    check("lb_req_drop", 34'(mem_req), 34'(0));
    @(negedge clk);
    check("lb_rsp_pulse", 34'(rsp_valid), 34'(0));

    // LHU 0x201: lanes 1-2, zero-extended
    exp_q.push_back({ERR_NONE, 32'h0000_F00F});
    issue(1'b0, F3_HU, 32'h0000_0201, 32'h0);
    @(negedge clk);
    check("lhu_byte_en", 34'(mem_byte_en), 34'b0110);
    #4;
    ack_now(32'h12F0_0F34, 1'b0);
    @(negedge clk);
    check("lhu_rsp_t2", 34'(rsp_valid), 34'(1));

    // LH 0x203: misaligned, answered at T+1 without a memory request
    exp_q.push_back({ERR_MISALIGN, 32'h0});
    issue(1'b0, F3_H, 32'h0000_0203, 32'h0);
    @(negedge clk);
    check("lh_mis_rsp_t1", 34'(rsp_valid), 34'(1));
    check("lh_mis_no_req", 34'(mem_req), 34'(0));
    @(negedge clk);
    check("lh_mis_no_req2", 34'(mem_req), 34'(0));

    // SB 0x402: data moved to lane 2, other lanes zero
    exp_q.push_back({ERR_NONE, 32'h0});
    issue(1'b1, F3_B, 32'h0000_0402, 32'h1234_56A5);
    @(negedge clk);
    check("sb_mem_we", 34'(mem_we), 34'(1));
    check("sb_byte_en", 34'(mem_byte_en), 34'b0100);
    check("sb_wdata", 34'(mem_wdata), 34'h00A5_0000);
    check("sb_addr", 34'(mem_addr), 34'h400);
    #4;
    ack_now(32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    check("sb_rsp_t2", 34'(rsp_valid), 34'(1));

    // SH 0x006: upper half word
    exp_q.push_back({ERR_NONE, 32'h0});
    issue(1'b1, F3_H, 32'h0000_0006, 32'hFFFF_BEEF);
    @(negedge clk);
    check("sh_byte_en", 34'(mem_byte_en), 34'b1100);
    check("sh_wdata", 34'(mem_wdata), 34'hBEEF_0000);
    #4;
    ack_now(32'h0, 1'b0);

    // illegal funct3 011 load
    exp_q.push_back({ERR_FAULT, 32'h0});
    issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
    @(negedge clk);
    check("f3_011_rsp_t1", 34'(rsp_valid), 34'(1));
    check("f3_011_no_req", 34'(mem_req), 34'(0));

    // store with funct3 100 is illegal too
    exp_q.push_back({ERR_FAULT, 32'h0});
    issue(1'b1, F3_BU, 32'h0000_0000, 32'h0);
    @(negedge clk);
    check("sbu_rsp_t1", 34'(rsp_valid), 34'(1));

    // LW with bus fault
    exp_q.push_back({ERR_FAULT, 32'h0});
    issue(1'b0, F3_W, 32'h0000_0010, 32'h0);
    @(negedge clk);
    check("lw_err_byte_en", 34'(mem_byte_en), 34'b1111);
    #4;
    ack_now(32'h1234_5678, 1'b1);
    @(negedge clk);
    check("lw_err_rsp_t2", 34'(rsp_valid), 34'(1));

    // timeout: mem_req for exactly 4 cycles, response in the 5th
    exp_q.push_back({ERR_TIMEOUT, 32'h0});
    issue(1'b0, F3_W, 32'h0000_0020, 32'h0);
    req_cycles = 0;
    rsp_cyc    = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (mem_req) req_cycles++;
      if (rsp_valid && rsp_cyc == 0) rsp_cyc = i;
    end
    check("to_req_cycles", 34'(req_cycles), 34'(4));
    check("to_rsp_cycle", 34'(rsp_cyc), 34'(5));

    // ack on the 4th REQ cycle beats expiry
    exp_q.push_back({ERR_NONE, 32'hCAFE_F00D});
    issue(1'b0, F3_W, 32'h0000_0030, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("ack4_mem_req", 34'(mem_req), 34'(1));
    #4;
    ack_now(32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    check("ack4_rsp", 34'(rsp_valid), 34'(1));
    @(negedge clk);

    // reset during REQ: mem_req drops at once, no response
    issue(1'b0, F3_W, 32'h0000_0040, 32'h0);
    @(negedge clk);
    check("rstmid_req_before", 34'(mem_req), 34'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("rstmid_req_async", 34'(mem_req), 34'(0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rstmid_no_rsp", 34'(rsp_valid), 34'(0));
    end
    rst_n = 1'b1;

    // next access after reset: LBU 0x41 lane 1, zero-extended
    exp_q.push_back({ERR_NONE, 32'h0000_0099});
    issue(1'b0, F3_BU, 32'h0000_0041, 32'h0);
    @(negedge clk);
    check("post_rst_byte_en", 34'(mem_byte_en), 34'b0010);
    #4;
    ack_now(32'h0000_9900, 1'b0);
    @(negedge clk);
    check("post_rst_rsp", 34'(rsp_valid), 34'(1));

    repeat (3) @(negedge clk);
    check("exp_q_drained", 34'(exp_q.size()), 34'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
